// File: rtl/audio_spi_pkg.sv
// Shared constants and types for the audio SPI bus blocks.
// LTC2624 command/address codes, frame width and DAC transmitter states.
package audio_spi_pkg;

    localparam logic [3:0] LTC_CMD_WR_UPD = 4'b0011;
    localparam logic [3:0] LTC_ADDR_ALL   = 4'b1111;
    localparam int         FRAME_W        = 32;
    localparam int         BIT_CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_END
    } dac_state_t;

    function automatic logic [FRAME_W-1:0] ltc_frame(
        input logic [3:0]  cmd,
        input logic [3:0]  addr,
        input logic [11:0] sample
    );
        return {8'h00, cmd, addr, sample, 4'h0};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock phase generator: strobes for the SCK rise and the bit advance.
// Shared by the DAC transmitter and the ADC receiver.
module spi_sck_gen #(
    parameter int HALF_PERIOD = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_rise,
    output logic o_adv
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_tick;

    assign w_tick = i_en && (r_cnt == LAST);
    assign o_rise = w_tick & ~r_phase;
    assign o_adv  = w_tick & r_phase;

    // r_phase: 0 = SCK low half, 1 = SCK high half
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_dac_tx.sv
// LTC2624 serial transmitter: one 32-bit write-and-update frame per DAC window.
// Optional DAC_CLR_EN adds an active-low dac_clr pulse after reset.
module spi_dac_tx
    import audio_spi_pkg::*;
#(
    parameter int         DATA_W      = 12,
    parameter logic [3:0] CMD         = LTC_CMD_WR_UPD,
    parameter logic [3:0] ADDR        = LTC_ADDR_ALL,
    parameter int         HALF_PERIOD = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enabledac,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              dac_cs,
    output logic              busy,
    output logic              frame_done
`ifdef DAC_CLR_EN
    ,
    output logic              dac_clr
`endif
);

    dac_state_t           r_state;
    logic                 r_en;
    logic                 r_full;
    logic [DATA_W-1:0]    r_hold;
    logic [DATA_W-1:0]    r_last;
    logic [FRAME_W-1:0]   r_shift;
    logic [BIT_CNT_W-1:0] r_bit;
    logic                 r_sck;
    logic                 r_mosi;
    logic                 r_cs;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_armed;
    logic                 w_start;
    logic                 w_xfer;
    logic                 w_rise;
    logic                 w_adv;
    logic [DATA_W-1:0]    w_sample;
    logic [FRAME_W-1:0]   w_word;

`ifdef DAC_CLR_EN
    logic [2:0] r_clr_cnt;
    logic       r_clr_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clr_cnt <= 3'd0;
            r_clr_n   <= 1'b0;
        end else if (r_clr_cnt != 3'd4) begin
            r_clr_cnt <= r_clr_cnt + 3'd1;
            r_clr_n   <= (r_clr_cnt == 3'd3);
        end
    end

    assign dac_clr = r_clr_n;
    assign w_armed = r_clr_n;
`else
    assign w_armed = 1'b1;
`endif

    assign w_start  = enabledac & ~r_en & w_armed;
    assign w_xfer   = sample_valid & ~r_full;
    assign w_sample = r_full ? r_hold : r_last;
    assign w_word   = ltc_frame(CMD, ADDR, w_sample);

    assign sample_ready = ~r_full;
    assign spi_sck      = r_sck;
    assign spi_mosi     = r_mosi;
    assign dac_cs       = r_cs;
    assign busy         = r_busy;
    assign frame_done   = r_done;

    spi_sck_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_sck (
        .i_clk (clock),
        .i_rst (reset),
        .i_en  (r_state == ST_SHIFT),
        .o_rise(w_rise),
        .o_adv (w_adv)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_en <= 1'b0;
        end else begin
            r_en <= enabledac;
        end
    end

    // A full register is never offered a transfer, so fill and drain never collide
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
            r_hold <= '0;
            r_last <= '0;
        end else begin
            if (w_xfer) begin
                r_full <= 1'b1;
                r_hold <= sample_data;
            end else if (r_state == ST_LOAD && r_full) begin
                r_full <= 1'b0;
            end
            if (r_state == ST_LOAD && r_full) begin
                r_last <= r_hold;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_shift <= w_word;
                    r_mosi  <= w_word[FRAME_W-1];
                    r_bit   <= BIT_CNT_W'(FRAME_W - 1);
                    r_cs    <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        r_sck <= 1'b1;
                    end else if (w_adv) begin
                        r_sck <= 1'b0;
                        if (r_bit == '0) begin
                            r_state <= ST_END;
                        end else begin
                            r_bit   <= r_bit - 1'b1;
                            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                            r_mosi  <= r_shift[FRAME_W-2];
                        end
                    end
                end
                ST_END: begin
                    r_sck   <= 1'b0;
                    r_mosi  <= 1'b0;
                    r_cs    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_tx.sv
// Directed self-checking bench for spi_dac_tx (HALF_PERIOD = 2).
// Build with DAC_CLR_EN defined to also exercise the dac_clr window.
module tb_spi_dac_tx;

    logic        clock = 1'b0;
    logic        reset;
    logic        enabledac;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        spi_sck;
    logic        spi_mosi;
    logic        dac_cs;
    logic        busy;
    logic        frame_done;
`ifdef DAC_CLR_EN
    logic        dac_clr;
`endif

    int checks = 0;
    int errors = 0;

    spi_dac_tx #(
        .HALF_PERIOD(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enabledac   (enabledac),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .dac_cs      (dac_cs),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef DAC_CLR_EN
        ,
        .dac_clr     (dac_clr)
`endif
    );

    always #5 clock = ~clock;

    // Bus monitor: captures MOSI on SCK rises and counts frame events
    int          mon_rises = 0;
    int          mon_cslow = 0;
    int          mon_falls = 0;
    int          mon_done  = 0;
    logic [31:0] mon_word  = '0;
    logic        sck_prev  = 1'b0;
    logic        cs_prev   = 1'b1;

    always @(negedge clock) begin
        if (!sck_prev && spi_sck) begin
            mon_word  = {mon_word[30:0], spi_mosi};
            mon_rises = mon_rises + 1;
        end
        sck_prev = spi_sck;
        if (!dac_cs) mon_cslow = mon_cslow + 1;
        if (cs_prev && !dac_cs) mon_falls = mon_falls + 1;
        cs_prev = dac_cs;
        if (frame_done) mon_done = mon_done + 1;
    end

    task automatic offer(input logic [11:0] d);
        @(posedge clock); #1;
        sample_valid = 1'b1;
        sample_data  = d;
        @(posedge clock); #1;
        sample_valid = 1'b0;
    endtask

    task automatic pulse_en();
        @(posedge clock); #1;
        enabledac = 1'b1;
        @(posedge clock); #1;
        enabledac = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit to);
        to = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clock); #1;
            if (mon_done > base) begin
                to = 1'b0;
                break;
            end
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        enabledac    = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        #1;
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL rst_sck got %b want 0", spi_sck); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", spi_mosi); end
        checks++; if (dac_cs !== 1'b1) begin errors++; $display("FAIL rst_cs got %b want 1", dac_cs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", frame_done); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", sample_ready); end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        checks++; if (dac_cs !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_rst cs=%b busy=%b want 1 0", dac_cs, busy); end
    endtask

    task automatic test_frame();
        int b_r, b_c, b_f, b_d;
        bit to;
        b_r = mon_rises; b_c = mon_cslow; b_f = mon_falls; b_d = mon_done;
        offer(12'hABC);
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL ready_after_accept got %b want 0", sample_ready); end
        @(posedge clock); #1;
        enabledac = 1'b1;
        @(posedge clock); #1;
        enabledac = 1'b0;
        checks++; if (dac_cs !== 1'b1) begin errors++; $display("FAIL cs_lat1 got %b want 1", dac_cs); end
        @(posedge clock); #1;
        checks++; if (dac_cs !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL cs_lat2 cs=%b busy=%b want 0 1", dac_cs, busy); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL ready_after_load got %b want 1", sample_ready); end
        wait_done(b_d, to);
        checks++; if (to) begin errors++; $display("FAIL frame1_timeout got timeout want frame_done"); end
        checks++; if (mon_word !== 32'h003F_ABC0) begin errors++; $display("FAIL frame1_word got %h want 003fabc0", mon_word); end
        checks++; if (mon_rises - b_r != 32) begin errors++; $display("FAIL frame1_rises got %0d want 32", mon_rises - b_r); end
        checks++; if (mon_cslow - b_c != 129) begin errors++; $display("FAIL frame1_cslow got %0d want 129", mon_cslow - b_c); end
        checks++; if (mon_falls - b_f != 1) begin errors++; $display("FAIL frame1_falls got %0d want 1", mon_falls - b_f); end
        checks++; if (mon_done - b_d != 1) begin errors++; $display("FAIL frame1_done got %0d want 1", mon_done - b_d); end
    endtask

    task automatic test_retransmit();
        int b_r, b_d;
        bit to;
        b_r = mon_rises; b_d = mon_done;
        pulse_en();
        wait_done(b_d, to);
        checks++; if (to) begin errors++; $display("FAIL retx_timeout got timeout want frame_done"); end
        checks++; if (mon_word !== 32'h003F_ABC0) begin errors++; $display("FAIL retx_word got %h want 003fabc0", mon_word); end
        checks++; if (mon_rises - b_r != 32) begin errors++; $display("FAIL retx_rises got %0d want 32", mon_rises - b_r); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL retx_ready got %b want 1", sample_ready); end
    endtask

    task automatic test_overwrite();
        int b_d;
        bit to;
        offer(12'h456);
        @(posedge clock); #1;
        sample_valid = 1'b1;
        sample_data  = 12'h123;
        @(posedge clock); #1;
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL ovw_ready_full got %b want 0", sample_ready); end
        b_d = mon_done;
        enabledac = 1'b1;
        @(posedge clock); #1;
        enabledac = 1'b0;
        @(posedge clock); #1;
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL ovw_ready_load got %b want 1", sample_ready); end
        wait_done(b_d, to);
        sample_valid = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL ovw_timeout got timeout want frame_done"); end
        checks++; if (mon_word !== 32'h003F_4560) begin errors++; $display("FAIL ovw_word got %h want 003f4560", mon_word); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL ovw_refill got %b want 0", sample_ready); end
        b_d = mon_done;
        pulse_en();
        wait_done(b_d, to);
        checks++; if (mon_word !== 32'h003F_1230 || to) begin errors++; $display("FAIL ovw_next_word got %h to=%b want 003f1230", mon_word, to); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL ovw_empty got %b want 1", sample_ready); end
    endtask

    task automatic test_held_high();
        int b_f, b_d;
        bit to;
        b_f = mon_falls; b_d = mon_done;
        @(posedge clock); #1;
        enabledac = 1'b1;
        repeat (200) @(posedge clock);
        #1;
        enabledac = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (mon_falls - b_f != 1) begin errors++; $display("FAIL held_frames got %0d want 1", mon_falls - b_f); end
        checks++; if (mon_done - b_d != 1) begin errors++; $display("FAIL held_done got %0d want 1", mon_done - b_d); end
        b_f = mon_falls; b_d = mon_done;
        pulse_en();
        repeat (20) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid got %b want 1", busy); end
        pulse_en();
        wait_done(b_d, to);
        repeat (150) @(posedge clock);
        #1;
        checks++; if (mon_falls - b_f != 1) begin errors++; $display("FAIL busy_frames got %0d want 1", mon_falls - b_f); end
        checks++; if (mon_done - b_d != 1) begin errors++; $display("FAIL busy_done got %0d want 1", mon_done - b_d); end
        checks++; if (mon_word !== 32'h003F_1230) begin errors++; $display("FAIL busy_word got %h want 003f1230", mon_word); end
    endtask

    task automatic test_reset_mid();
        int b_r, b_c, b_d;
        bit hit;
        bit to;
        b_r = mon_rises;
        hit = 1'b0;
        pulse_en();
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            if (mon_rises - b_r == 16) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL mid_reach got %0d rises want 16", mon_rises - b_r); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dac_cs !== 1'b1) begin errors++; $display("FAIL mid_cs got %b want 1", dac_cs); end
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL mid_sck got %b want 0", spi_sck); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        checks++; if (sample_ready !== 1'b1 || dac_cs !== 1'b1) begin errors++; $display("FAIL mid_idle ready=%b cs=%b want 1 1", sample_ready, dac_cs); end
        offer(12'h7E5);
        b_r = mon_rises; b_c = mon_cslow; b_d = mon_done;
        pulse_en();
        wait_done(b_d, to);
        checks++; if (to) begin errors++; $display("FAIL mid_timeout got timeout want frame_done"); end
        checks++; if (mon_word !== 32'h003F_7E50) begin errors++; $display("FAIL mid_word got %h want 003f7e50", mon_word); end
        checks++; if (mon_rises - b_r != 32) begin errors++; $display("FAIL mid_rises got %0d want 32", mon_rises - b_r); end
        checks++; if (mon_cslow - b_c != 129) begin errors++; $display("FAIL mid_cslow got %0d want 129", mon_cslow - b_c); end
    endtask

`ifdef DAC_CLR_EN
    task automatic test_clr();
        int b_f, b_d;
        bit to;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if (dac_clr !== 1'b0) begin errors++; $display("FAIL clr_low0 got %b want 0", dac_clr); end
        b_f = mon_falls; b_d = mon_done;
        @(posedge clock); #1;
        enabledac = 1'b1;
        @(posedge clock); #1;
        checks++; if (dac_clr !== 1'b0) begin errors++; $display("FAIL clr_low2 got %b want 0", dac_clr); end
        enabledac = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++; if (dac_clr !== 1'b1) begin errors++; $display("FAIL clr_high got %b want 1", dac_clr); end
        checks++; if (dac_cs !== 1'b1 || mon_falls != b_f) begin errors++; $display("FAIL clr_ignored cs=%b falls=%0d want 1 0", dac_cs, mon_falls - b_f); end
        @(posedge clock); #1;
        enabledac = 1'b1;
        @(posedge clock); #1;
        enabledac = 1'b0;
        @(posedge clock); #1;
        checks++; if (dac_cs !== 1'b0) begin errors++; $display("FAIL clr_start got %b want 0", dac_cs); end
        wait_done(b_d, to);
        checks++; if (to || mon_falls - b_f != 1) begin errors++; $display("FAIL clr_frame to=%b falls=%0d want 0 1", to, mon_falls - b_f); end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_retransmit();
        test_overwrite();
        test_held_high();
        test_reset_mid();
`ifdef DAC_CLR_EN
        test_clr();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_dac_tx.md
Name: spi_dac_tx

Overview:
- Serial transmitter for the LTC2624 DAC on the audio SPI bus.
- Consumes 12-bit samples through a valid/ready handshake and buffers one sample.
- Starts one 32-bit write-and-update frame each time the sequencer's DAC window opens, and drives SCK, MOSI and the active-low DAC chip select.
- Sits downstream of the bus sequencer, which owns the window timing; this block owns the bit-level framing.

Parameters:
- DATA_W, 12: sample width; fixed by the DAC, must be 12.
- CMD, 4'b0011: command nibble (write to and update DAC n).
- ADDR, 4'b1111: address nibble (all channels).
- HALF_PERIOD, 2: SCK half-period in clock cycles; must be at least 1.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- enabledac  in  1  DAC window from the sequencer; a rising edge requests a frame.
- sample_data  in  12  sample to transmit.
- sample_valid  in  1  sample_data is valid.
- sample_ready  out  1  holding register is empty.
- spi_sck  out  1  SPI clock; idles low.
- spi_mosi  out  1  serial data, MSB first.
- dac_cs  out  1  DAC chip select, active low.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset values: spi_sck=0, spi_mosi=0, dac_cs=1, busy=0, frame_done=0, sample_ready=1. Holding register empty; last-sent value cleared to 0; edge-detect register cleared to 0.
- Handshake: a transfer occurs when sample_valid and sample_ready are both high at a posedge. It fills the holding register, and sample_ready drops the next cycle. The register empties when its value is loaded into a frame.
- Frame word, MSB first: 8'h00, CMD, ADDR, sample[11:0], 4'h0 (32 bits total).
- Sample selection:
  - If the holding register is full at frame start, its value is loaded and also stored as last-sent.
  - If it is empty, last-sent is retransmitted.
- Edge detection: enabledac is registered once and a rise is detected from that registered value.
- States:
  - IDLE: wait for a rise. Rises while not IDLE are ignored.
  - LOAD, 1 cycle: load the shift register, dac_cs=0, busy=1, spi_mosi=bit 31.
  - SHIFT: each bit holds SCK low for HALF_PERIOD cycles, then high for HALF_PERIOD cycles. spi_mosi updates only on the high-to-low transition. The bit counter runs 31 down to 0.
  - END, 1 cycle: spi_sck=0, dac_cs=1, busy=0, frame_done=1, then return to IDLE.
- Latency:
  - dac_cs falls 2 cycles after enabledac rises (edge-detect register + LOAD).
  - Frame length from dac_cs low to dac_cs high: 1 + 64·HALF_PERIOD cycles.
  - Exactly 32 SCK rising edges per frame.
- Simultaneous handshake and frame start:
  - Not full at LOAD: the old value or last-sent is used for this frame, and the new sample is held for the next frame.
  - Full at LOAD while a transfer is offered: the register empties and refills in the same cycle. sample_ready stays 0 that cycle, so this case cannot occur.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously); dac_cs=1 ends the frame. No partial frame resumes.
- enabledac held high: a single frame only; a new frame needs a fall and then a rise.

Optional Feature:
- DAC_CLR_EN defined:
  - Adds output dac_clr (active low).
  - dac_clr=0 during reset and for 4 clocks after reset deasserts, then 1.
  - Rises arriving while dac_clr=0 are ignored.
- DAC_CLR_EN undefined: no port, and rises are accepted right after reset.

Decomposition:
- Shared package (audio_spi_pkg):
  - LTC2624 command/address constants.
  - Frame width 32.
  - State encoding (IDLE, LOAD, SHIFT, END).
- Sub-module spi_sck_gen: HALF_PERIOD counter producing phase and bit-advance strobes. Reusable by the ADC receiver.

Test Plan:
- Reset, accept 12'hABC, then pulse enabledac → MOSI captured on the 32 SCK rises equals 32'h003F_ABC0; dac_cs low for 1+64·2=129 cycles; one frame_done pulse.
- No sample offered, second enabledac rise → frame retransmits 12'hABC.
- Second sample_valid while full → sample_ready=0, data not overwritten; 12'h123 is accepted only after the next LOAD.
- enabledac held high 200 cycles, plus a pulse while busy → exactly one frame each time; no extra frame while busy.
- reset asserted at bit 15 → dac_cs=1, spi_sck=0, busy=0 immediately; the next frame is complete and correct.
- With DAC_CLR_EN: rise at cycle 2 after reset → ignored, dac_clr=0; rise at cycle 6 → frame starts.
